// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: synchronizes the receiver byte history, decodes make/break
// sequences into {ext, release, code} events queued in a small FIFO, and tracks held keys.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] keycode,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [9:0]  ev_data,
  output logic [5:0]  held,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_discard = 1'b1;
      default:                                                 is_discard = 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] key_mask(input logic [9:0] ev);
    key_mask = 6'b0;
    case ({ev[9], ev[7:0]})
      9'h175: key_mask = 6'b000001;
      9'h172: key_mask = 6'b000010;
      9'h16B: key_mask = 6'b000100;
      9'h174: key_mask = 6'b001000;
      9'h029: key_mask = 6'b010000;
      9'h05A: key_mask = 6'b100000;
      default: key_mask = 6'b0;
    endcase
  endfunction

  logic [31:0] s1, s2, s3, last_word;
  logic        strobe, strobe_q;
  logic [7:0]  b;
  state_t      state, state_n;
  logic [2:0]  skip_cnt, skip_n;
  logic        push;
  logic [9:0]  push_ev;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, full, do_push;

  // Synchronizer and byte strobe: one strobe per new stable word
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 32'h0;
      s2        <= 32'h0;
      s3        <= 32'h0;
      last_word <= 32'h0;
      strobe_q  <= 1'b0;
    end else begin
      s1       <= keycode;
      s2       <= s1;
      s3       <= s2;
      strobe_q <= strobe;
      if (strobe) last_word <= s2;
    end
  end

  assign strobe = (s2 == s3) && (s2 != last_word) && !strobe_q;
  assign b      = s2[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_n;
      skip_cnt <= skip_n;
    end
  end

  always_comb begin
    state_n = state;
    skip_n  = skip_cnt;
    push    = 1'b0;
    push_ev = 10'h000;
    if (strobe) begin
      case (state)
        IDLE: begin
          if (b == 8'hE0)      state_n = EXT;
          else if (b == 8'hF0) state_n = BRK;
          else if (b == 8'hE1) begin
            state_n = PAUSE;
            skip_n  = 3'd7;
          end else if (!is_discard(b)) begin
            push    = 1'b1;
            push_ev = {2'b00, b};
          end
        end
        EXT: begin
          if (b == 8'hF0)      state_n = EXT_BRK;
          else if (b == 8'hE0) state_n = EXT;
          else begin
            state_n = IDLE;
            if (!is_discard(b)) begin
              push    = 1'b1;
              push_ev = {2'b10, b};
            end
          end
        end
        BRK: begin
          if (b == 8'hE0)      state_n = EXT;
          else if (b == 8'hF0) state_n = BRK;
          else begin
            state_n = IDLE;
            if (!is_discard(b)) begin
              push    = 1'b1;
              push_ev = {2'b01, b};
            end
          end
        end
        EXT_BRK: begin
          if (b != 8'hE0 && b != 8'hF0) begin
            state_n = IDLE;
            if (!is_discard(b)) begin
              push    = 1'b1;
              push_ev = {2'b11, b};
            end
          end
        end
        PAUSE: begin
          // Pause sequence carries no key information; just count it off
          if (skip_cnt <= 3'd1) begin
            state_n = IDLE;
            skip_n  = 3'd0;
          end else begin
            skip_n = skip_cnt - 3'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Event FIFO; held tracks every decoded event, dropped or not
  assign full     = (count == FULL_CNT);
  assign ev_valid = (count != '0);
  assign pop      = ev_valid && ev_ready;
  assign do_push  = push && (!full || pop);
  assign ev_data  = ev_valid ? mem[rd_ptr] : 10'h000;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      held     <= 6'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      if (push) begin
        if (push_ev[8]) held <= held & ~key_mask(push_ev);
        else            held <= held | key_mask(push_ev);
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of byte sequences plus hand-written corner cases.
module tb_ps2_key_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] keycode;
  logic        ev_valid;
  logic        ev_ready;
  logic [9:0]  ev_data;
  logic [5:0]  held;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .keycode(keycode), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_data(ev_data), .held(held), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [3:0][7:0]  bytes;
    logic [9:0]       exp_ev;
    logic [5:0]       exp_held;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    keycode  = 32'h0;
    ev_ready = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] nb);
    @(negedge clk);
    keycode = {keycode[23:0], nb};
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [9:0] exp);
    #1;
    check({name, "_valid"}, {31'b0, ev_valid}, 32'd1);
    check({name, "_data"}, {22'b0, ev_data}, {22'b0, exp});
    pop_one();
  endtask

  initial begin
    int edges;
    logic [7:0] seq_a[9];
    logic [7:0] fill[6];

    vecs[0]  = '{1, {8'h00, 8'h00, 8'h00, 8'h1C}, 10'h01C, 6'b000000};
    vecs[1]  = '{2, {8'h00, 8'h00, 8'h75, 8'hE0}, 10'h275, 6'b000001};
    vecs[2]  = '{3, {8'h00, 8'h75, 8'hF0, 8'hE0}, 10'h375, 6'b000000};
    vecs[3]  = '{1, {8'h00, 8'h00, 8'h00, 8'h29}, 10'h029, 6'b010000};
    vecs[4]  = '{2, {8'h00, 8'h00, 8'h29, 8'hF0}, 10'h129, 6'b000000};
    vecs[5]  = '{2, {8'h00, 8'h00, 8'h6B, 8'hE0}, 10'h26B, 6'b000100};
    vecs[6]  = '{1, {8'h00, 8'h00, 8'h00, 8'h6B}, 10'h06B, 6'b000100};
    vecs[7]  = '{3, {8'h00, 8'h6B, 8'hF0, 8'hE0}, 10'h36B, 6'b000000};
    vecs[8]  = '{3, {8'h00, 8'h74, 8'hE0, 8'hF0}, 10'h274, 6'b001000};
    vecs[9]  = '{3, {8'h00, 8'h72, 8'hE0, 8'hE0}, 10'h272, 6'b001010};
    vecs[10] = '{4, {8'h74, 8'hF0, 8'hF0, 8'hE0}, 10'h374, 6'b000010};
    vecs[11] = '{2, {8'h00, 8'h00, 8'h5A, 8'hAA}, 10'h05A, 6'b100010};
    vecs[12] = '{3, {8'h00, 8'h1C, 8'hFA, 8'hE0}, 10'h01C, 6'b100010};

    rst = 1'b1;
    keycode = 32'h0;
    ev_ready = 1'b0;
    do_reset();
    #1;
    check("rst_valid", {31'b0, ev_valid}, 32'd0);
    check("rst_data", {22'b0, ev_data}, 32'd0);
    check("rst_held", {26'b0, held}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);

    // Latency: ev_valid must rise exactly at the 4th edge after keycode changes
    @(negedge clk);
    keycode = 32'h0000001C;
    edges = 0;
    while (!ev_valid && edges < 12) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("latency_edges", edges, 32'd4);
    check("latency_data", {22'b0, ev_data}, 32'h01C);
    check("latency_held", {26'b0, held}, 32'd0);
    pop_one();

    // Table of decoded sequences
    foreach (vecs[i]) begin
      for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].bytes[j]);
      check($sformatf("vec%0d_held", i), {26'b0, held}, {26'b0, vecs[i].exp_held});
      pop_check($sformatf("vec%0d", i), vecs[i].exp_ev);
      #1;
      check($sformatf("vec%0d_empty", i), {31'b0, ev_valid}, 32'd0);
    end

    do_reset();
    #1;
    check("rst2_held", {26'b0, held}, 32'd0);
    check("rst2_valid", {31'b0, ev_valid}, 32'd0);

    // Overflow: six makes into a depth-4 FIFO
    fill = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    for (int i = 0; i < 6; i++) begin
      send_byte(fill[i]);
      if (i == 3) check("ovf_before", {31'b0, overflow}, 32'd0);
    end
    check("ovf_set", {31'b0, overflow}, 32'd1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovf_pop%0d", i), {2'b00, fill[i]});
    #1;
    check("ovf_empty", {31'b0, ev_valid}, 32'd0);
    check("ovf_sticky", {31'b0, overflow}, 32'd1);

    // Full FIFO with a pop on the push edge
    do_reset();
    for (int i = 1; i < 5; i++) send_byte(fill[i]);
    @(negedge clk);
    keycode = {keycode[23:0], 8'h2E};
    repeat (3) @(posedge clk);
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("full_pp_ovf", {31'b0, overflow}, 32'd0);
    pop_check("full_pp0", 10'h01E);
    pop_check("full_pp1", 10'h026);
    pop_check("full_pp2", 10'h025);
    pop_check("full_pp3", 10'h02E);
    #1;
    check("full_pp_empty", {31'b0, ev_valid}, 32'd0);

    // Pause sequence is swallowed, following key decodes normally
    do_reset();
    seq_a = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
    for (int i = 0; i < 9; i++) begin
      send_byte(seq_a[i]);
      if (i == 7) check("pause_none", {31'b0, ev_valid}, 32'd0);
    end
    check("pause_held", {26'b0, held}, 32'b010000);
    pop_check("pause_ev", 10'h029);
    #1;
    check("pause_single", {31'b0, ev_valid}, 32'd0);

    // Reset between E0 and the code byte discards the prefix
    do_reset();
    send_byte(8'hE0);
    @(negedge clk);
    rst = 1'b1;
    keycode = {keycode[23:0], 8'h5A};
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_held", {26'b0, held}, 32'b100000);
    pop_check("midrst_ev", 10'h05A);

    // ev_ready with an empty FIFO does nothing
    @(negedge clk);
    ev_ready = 1'b1;
    repeat (3) @(negedge clk);
    ev_ready = 1'b0;
    send_byte(8'h1C);
    pop_check("empty_rdy", 10'h01C);
    #1;
    check("empty_rdy_after", {31'b0, ev_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
